regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback sources (ALU, LSU, MULDIV). Each cycle it grants one source by round-robin and captures the winner in a one-entry writeback stage. It drives the regfile write port from that stage one cycle later. It also forwards the staged value to the two read ports, so reads issued during the in-flight cycle see the new data.

Parameters:
NUM_REQ, 3, number of writeback requesters; index 0 is ALU by convention
XLEN, 64, register data width
AW, 5, register address width (32 architectural registers)
CNT_W, 16, width of the saturating contention counter

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-source writeback request
req_ready  output  NUM_REQ  per-source grant, one-hot or zero
req_rd_addr  input  NUM_REQ*AW  packed destination addresses, source i at [i*AW +: AW]
req_rd_data  input  NUM_REQ*XLEN  packed write data, source i at [i*XLEN +: XLEN]
rf_write_enable  output  1  to regfile write_enable
rf_rd_addr  output  AW  to regfile rd_addr
rf_rd_data  output  XLEN  to regfile rd_data
rs1_addr  input  AW  read address 1 (same value presented to regfile)
rs2_addr  input  AW  read address 2
rs1_fwd_valid  output  1  staged write matches rs1_addr
rs1_fwd_data  output  XLEN  staged data for rs1
rs2_fwd_valid  output  1  staged write matches rs2_addr
rs2_fwd_data  output  XLEN  staged data for rs2
contention_cnt  output  CNT_W  saturating count of cycles with more than one req_valid

Behaviour:
- Clock and reset: single clock domain, clk; asynchronous active-low reset, rst_n.
- Reset values: rf_write_enable=0, rf_rd_addr=0, rf_rd_data=0, contention_cnt=0, rr_ptr=0, stage_valid=0.
- Since rf_* are registered, fwd_valid=0 during reset. req_ready is combinational from req_valid and rr_ptr.
- Arbitration:
  - The candidate order is rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first valid source wins, and only that req_ready bit is set.
  - If no source is valid, req_ready is all zero.
  - The write port never back-pressures, so a grant is given in every cycle that has any request.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A source holds valid, address and data stable until it is granted. The arbiter does not check this.
  - Dropping valid before grant is permitted and is not an error.
- Pointer: on any transfer from source i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Stage (one register set: stage_valid, addr, data):
  - On a transfer, the stage loads the winner's address and data. stage_valid <= (addr != 0).
  - With no transfer, stage_valid <= 0. Address and data may hold.
- Write port:
  - rf_write_enable = stage_valid; rf_rd_addr and rf_rd_data are the stage fields.
  - Latency is exactly 1 cycle from transfer to rf_write_enable, and the regfile commits on the following edge.
  - Throughput is 1 write per cycle; back-to-back transfers give a continuous write_enable.
- x0 writes: the transfer completes normally (ready asserted, pointer advances), but rf_write_enable stays 0. x0 never reaches the regfile.
- Forwarding:
  - rsN_fwd_valid = stage_valid && (stage addr == rsN_addr), purely combinational; rsN_fwd_data = stage data.
  - rsN_addr==0 never matches, because stage_valid already excludes x0.
  - The consumer muxes fwd_data over the regfile output when fwd_valid=1.
- Contention counter: increments on each cycle where popcount(req_valid) >= 2. It saturates at all-ones and does not wrap.
- Reset mid-operation: a staged write is discarded and not written. Requesters must re-present after reset; a transfer in the reset cycle is lost.
- Two sources may target the same register in consecutive cycles. The regfile receives them in grant order, and the later grant wins.

Decomposition:
- Shared package regfile_pkg: XLEN, AW, NUM_REGS=32, ZERO_REG=5'h0, and typedef wb_req_t {logic [AW-1:0] rd_addr; logic [XLEN-1:0] rd_data;}.
- One natural sub-module: rr_arbiter (NUM_REQ generic). It takes req and ptr, returns a one-hot grant and the grant index, and is reusable for the LSU port later.
- Stage, forwarding and counter stay in regfile_wb_arbiter.

Test Plan:
- Reset, then src0 valid with addr=5, data=0xDEAD_BEEF. Expect: req_ready=001 in cycle 0; in cycle 1, rf_write_enable=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF; rf_write_enable=0 in cycle 2.
- All three sources valid continuously for 6 cycles (addrs 1/2/3). Expect: grants 0,1,2,0,1,2, write_enable high for cycles 1-6, contention_cnt=6.
- src1 writes addr=0, data=0xFF. Expect: req_ready[1]=1, rr_ptr->2, rf_write_enable=0 next cycle, rs1_fwd_valid=0 with rs1_addr=0.
- src2 writes addr=7, data=0x1234 with rs1_addr=7 and rs2_addr=8 on the next cycle. Expect: rs1_fwd_valid=1 and rs1_fwd_data=0x1234; rs2_fwd_valid=0.
- src0 is granted addr=9. Assert rst_n=0 asynchronously before the next edge. Expect: rf_write_enable=0 immediately, no write to reg 9, rr_ptr=0 after release.
- Hold contention for 2^CNT_W + 3 cycles (or CNT_W=4 with 20 cycles). Expect: contention_cnt saturates at 0xF and holds.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file constants and writeback request type
package regfile_pkg;

    localparam int XLEN     = 64;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'h0;

    typedef struct packed {
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - generic round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    int cand;

    // Walk candidates ptr, ptr+1, ... modulo N; the first requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with one-entry stage and forwarding
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int AW      = regfile_pkg::AW,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AW-1:0]   req_rd_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_rd_data,
    output logic                    rf_write_enable,
    output logic [AW-1:0]           rf_rd_addr,
    output logic [XLEN-1:0]         rf_rd_data,
    input  logic [AW-1:0]           rs1_addr,
    input  logic [AW-1:0]           rs2_addr,
    output logic                    rs1_fwd_valid,
    output logic [XLEN-1:0]         rs1_fwd_data,
    output logic                    rs2_fwd_valid,
    output logic [XLEN-1:0]         rs2_fwd_data,
    output logic [CNT_W-1:0]        contention_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               stage_valid_q, stage_valid_d;
    logic [AW-1:0]      stage_addr_q, stage_addr_d;
    logic [XLEN-1:0]    stage_data_q, stage_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [AW-1:0]      win_addr;
    logic [XLEN-1:0]    win_data;
    logic               multi_req;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_any)
    );

    // The write port never stalls, so the arbiter grant is the ready.
    assign req_ready = grant;

    // Clearing the lowest set bit leaves something only if two or more requested.
    assign multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));

    // Select the winner's address and data using the one-hot grant.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_rd_addr[i*AW +: AW];
                win_data = req_rd_data[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state: pointer moves past the winner, stage captures it, counter saturates.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        stage_valid_d = 1'b0;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        cnt_d         = cnt_q;
        if (grant_any) begin
            rr_ptr_d      = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
            stage_addr_d  = win_addr;
            stage_data_d  = win_data;
            stage_valid_d = (win_addr != AW'(ZERO_REG));
        end
        if (multi_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any staged write so it never reaches the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            cnt_q         <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rf_write_enable = stage_valid_q;
    assign rf_rd_addr      = stage_addr_q;
    assign rf_rd_data      = stage_data_q;
    assign contention_cnt  = cnt_q;

    // x0 is never staged as valid, so it can never produce a forwarding hit.
    assign rs1_fwd_valid = stage_valid_q && (stage_addr_q == rs1_addr);
    assign rs2_fwd_valid = stage_valid_q && (stage_addr_q == rs2_addr);
    assign rs1_fwd_data  = stage_data_q;
    assign rs2_fwd_data  = stage_data_q;

endmodule
